// File: rtl/safe_lock_if.sv
// Keypad and code-checker handshake bundle for safe_lock_ctrl.
// slave = controller side, master = keypad/checker side.
interface safe_lock_if;
   logic key_val;
   logic key_data;
   logic key_rdy;
   logic ser_val;
   logic ser_data;
   logic chk_val;
   logic chk_ok;
   logic chk_rst;

   modport master (
      output key_val, key_data, chk_val, chk_ok,
      input  key_rdy, ser_val, ser_data, chk_rst
   );

   modport slave (
      input  key_val, key_data, chk_val, chk_ok,
      output key_rdy, ser_val, ser_data, chk_rst
   );
endinterface

// File: rtl/safe_lock_ctrl.sv
// Safe lock controller: serialises keypad bits to a code checker,
// handles unlock, timeouts and lockout. Optional alarm: SAFE_LOCK_ALARM_EN.
module safe_lock_ctrl #(
   parameter int CODE_LEN    = 4,
   parameter int MAX_FAIL    = 3,
   parameter int TIMEOUT_CYC = 32,
   parameter int UNLOCK_CYC  = 16,
   parameter int LOCKOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       rst,
   safe_lock_if.slave bus,
   output logic       unlock,
   output logic       locked_out,
`ifdef SAFE_LOCK_ALARM_EN
   output logic       alarm,
`endif
   output logic [2:0] fail_cnt
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_UNLOCK  = 3'd3;
   localparam logic [2:0] S_LOCK    = 3'd4;

   localparam int BW = $clog2(CODE_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int HOLD_MAX =
      (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
   localparam int CW = $clog2(HOLD_MAX + 1);

   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic [BW-1:0] BIT_LAST = BW'(CODE_LEN);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] HLD_ONE  = CW'(1);
   localparam logic [CW-1:0] UNL_LAST = CW'(UNLOCK_CYC - 1);
   localparam logic [CW-1:0] LCK_LAST = CW'(LOCKOUT_CYC - 1);
   localparam logic [2:0]    FAIL_LIM = 3'(MAX_FAIL);

   logic [2:0]    state;
   logic [BW-1:0] bit_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [CW-1:0] hold_cnt;
   logic [2:0]    fail_q;
   logic          ser_val_q;
   logic          ser_data_q;
   logic          chk_rst_q;

   logic          key_rdy_w;
   logic          accept;
   logic          in_chk;
   logic          res_hit;
   logic          tmo_hit;
   logic          fail_ev;
   logic [2:0]    fail_nxt;

   // Handshake decode and failure detection; a checker result beats
   // both a coincident key bit and a coincident timeout.
   always_comb begin
      key_rdy_w = !rst && (state == S_IDLE || state == S_COLLECT);
      accept    = bus.key_val && key_rdy_w;
      in_chk    = (state == S_COLLECT) || (state == S_WAIT);
      res_hit   = in_chk && bus.chk_val;
      tmo_hit   = in_chk && !accept && (tmo_cnt == TMO_LAST);
      fail_ev   = res_hit ? !bus.chk_ok : tmo_hit;
      fail_nxt  = fail_q + 3'd1;
   end

   // Main controller FSM with bit, timeout and hold counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         tmo_cnt    <= '0;
         hold_cnt   <= '0;
         fail_q     <= 3'd0;
         ser_val_q  <= 1'b0;
         ser_data_q <= 1'b0;
         chk_rst_q  <= 1'b0;
      end else begin
         ser_val_q  <= accept && !res_hit;
         ser_data_q <= accept && !res_hit && bus.key_data;
         chk_rst_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  bit_cnt <= BIT_ONE;
                  tmo_cnt <= '0;
                  state   <= (CODE_LEN == 1) ? S_WAIT : S_COLLECT;
               end
            end
            S_COLLECT, S_WAIT: begin
               if (res_hit && bus.chk_ok) begin
                  state    <= S_UNLOCK;
                  fail_q   <= 3'd0;
                  hold_cnt <= '0;
                  bit_cnt  <= '0;
                  tmo_cnt  <= '0;
               end else if (fail_ev) begin
                  chk_rst_q <= !res_hit;
                  fail_q    <= fail_nxt;
                  bit_cnt   <= '0;
                  tmo_cnt   <= '0;
                  hold_cnt  <= '0;
                  state     <= (fail_nxt == FAIL_LIM) ? S_LOCK : S_IDLE;
               end else if (accept) begin
                  bit_cnt <= bit_cnt + BIT_ONE;
                  tmo_cnt <= '0;
                  if (bit_cnt + BIT_ONE == BIT_LAST)
                     state <= S_WAIT;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_ONE;
               end
            end
            S_UNLOCK: begin
               if (hold_cnt == UNL_LAST) begin
                  hold_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  hold_cnt <= hold_cnt + HLD_ONE;
               end
            end
            S_LOCK: begin
               if (hold_cnt == LCK_LAST) begin
                  hold_cnt <= '0;
                  fail_q   <= 3'd0;
                  state    <= S_IDLE;
               end else begin
                  hold_cnt <= hold_cnt + HLD_ONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs are forced to their reset values while rst is high.
   always_comb begin
      bus.key_rdy  = key_rdy_w;
      bus.ser_val  = ser_val_q && !rst;
      bus.ser_data = ser_data_q && !rst;
      bus.chk_rst  = rst || chk_rst_q;
      unlock       = !rst && (state == S_UNLOCK);
      locked_out   = !rst && (state == S_LOCK);
      fail_cnt     = rst ? 3'd0 : fail_q;
   end

`ifdef SAFE_LOCK_ALARM_EN
   logic chk_val_q;

   // Remember last chk_val so tamper detection fires on its first cycle.
   always_ff @(posedge clk) begin
      if (rst) chk_val_q <= 1'b0;
      else     chk_val_q <= bus.chk_val;
   end

   // Alarm covers the whole lockout plus a checker pulse while held open.
   always_comb begin
      alarm = !rst && ((state == S_LOCK) ||
              (state == S_UNLOCK && bus.chk_val && !chk_val_q));
   end
`endif

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl (default parameters).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_safe_lock_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       unlock;
   logic       locked_out;
   logic [2:0] fail_cnt;
`ifdef SAFE_LOCK_ALARM_EN
   logic       alarm;
`endif
   int n_run  = 0;
   int n_fail = 0;

   safe_lock_if bus();

   safe_lock_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .unlock     (unlock),
      .locked_out (locked_out),
`ifdef SAFE_LOCK_ALARM_EN
      .alarm      (alarm),
`endif
      .fail_cnt   (fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.key_val  = 1'b1;
      bus.key_data = b;
      step();
      bus.key_val = 1'b0;
      check("ser_val_fwd", bus.ser_val, 1);
      check("ser_data_fwd", bus.ser_data, b);
      step();
      check("ser_val_gap", bus.ser_val, 0);
   endtask

   task automatic chk_pulse(input logic ok);
      bus.chk_val = 1'b1;
      bus.chk_ok  = ok;
      step();
      bus.chk_val = 1'b0;
      bus.chk_ok  = 1'b0;
   endtask

   initial begin
      int n;
      int bad;
      int k;
      logic [3:0] code;
      bus.key_val  = 1'b0;
      bus.key_data = 1'b0;
      bus.chk_val  = 1'b0;
      bus.chk_ok   = 1'b0;

      // reset state
      step();
      step();
      check("rst_key_rdy", bus.key_rdy, 0);
      check("rst_ser_val", bus.ser_val, 0);
      check("rst_chk_rst", bus.chk_rst, 1);
      check("rst_unlock", unlock, 0);
      check("rst_locked", locked_out, 0);
      check("rst_fail", fail_cnt, 0);
      rst = 1'b0;
      step();
      check("rel_key_rdy", bus.key_rdy, 1);
      check("rel_chk_rst", bus.chk_rst, 0);

      // chk_val in IDLE is ignored
      chk_pulse(1'b1);
      check("idle_chk_unlock", unlock, 0);

      // correct code 1,0,1,1
      code = 4'b1101;
      for (int i = 0; i < 4; i++) send_bit(code[i]);
      check("wait_key_rdy", bus.key_rdy, 0);
      chk_pulse(1'b1);
      n = 0;
      while (unlock && n < 40) begin
         n++;
         step();
      end
      check("unlock_len", n, 16);
      check("unl_fail", fail_cnt, 0);
      check("unl_key_rdy", bus.key_rdy, 1);

      // three wrong attempts, first one rejected early
      send_bit(1'b0);
      send_bit(1'b1);
      chk_pulse(1'b0);
      check("fail1", fail_cnt, 1);
      check("fail1_rdy", bus.key_rdy, 1);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      chk_pulse(1'b0);
      check("fail2", fail_cnt, 2);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      chk_pulse(1'b0);
      check("fail3_locked", locked_out, 1);
      check("fail3_cnt", fail_cnt, 3);
      bus.key_val  = 1'b1;
      bus.key_data = 1'b1;
      n = 0;
      bad = 0;
      k = 0;
      while (locked_out && n < 100) begin
         n++;
         if (bus.ser_val || bus.key_rdy) bad++;
`ifdef SAFE_LOCK_ALARM_EN
         if (alarm) k++;
`endif
         step();
      end
      bus.key_val = 1'b0;
      check("lock_len", n, 64);
      check("lock_key_ignored", bad, 0);
`ifdef SAFE_LOCK_ALARM_EN
      check("alarm_len", k, 64);
`endif
      check("lock_exit_fail", fail_cnt, 0);
      check("lock_exit_rdy", bus.key_rdy, 1);

      // timeout after one bit and 32 idle cycles
      bus.key_val  = 1'b1;
      bus.key_data = 1'b1;
      step();
      bus.key_val = 1'b0;
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (bus.chk_rst) begin
            k = i;
            break;
         end
      end
      check("tmo_cycle", k, 32);
      check("tmo_fail", fail_cnt, 1);
      check("tmo_rdy", bus.key_rdy, 1);
      step();
      check("tmo_pulse_end", bus.chk_rst, 0);

      // result and key in same COLLECT cycle: result wins
      send_bit(1'b1);
      bus.key_val  = 1'b1;
      bus.key_data = 1'b1;
      bus.chk_val  = 1'b1;
      bus.chk_ok   = 1'b1;
      step();
      bus.key_val = 1'b0;
      bus.chk_val = 1'b0;
      bus.chk_ok  = 1'b0;
      check("coll_ser_val", bus.ser_val, 0);
      check("coll_unlock", unlock, 1);
      check("coll_fail_clr", fail_cnt, 0);

      // reset during unlock cycle 5
      for (int i = 0; i < 4; i++) step();
      check("unl_c5", unlock, 1);
`ifdef SAFE_LOCK_ALARM_EN
      bus.chk_val = 1'b1;
      #1;
      check("tamper_alarm", alarm, 1);
      bus.chk_val = 1'b0;
`endif
      rst = 1'b1;
      step();
      check("mid_rst_unlock", unlock, 0);
      check("mid_rst_fail", fail_cnt, 0);
      rst = 1'b0;
      step();
      check("mid_rst_rdy", bus.key_rdy, 1);
      check("mid_rst_unl2", unlock, 0);

      // result coincides with timeout expiry: no chk_rst, single failure
      bus.key_val  = 1'b1;
      bus.key_data = 1'b0;
      step();
      bus.key_val = 1'b0;
      for (int i = 0; i < 31; i++) step();
      check("pre_tmo_rst", bus.chk_rst, 0);
      chk_pulse(1'b0);
      check("tie_chk_rst", bus.chk_rst, 0);
      check("tie_fail", fail_cnt, 1);
      check("tie_rdy", bus.key_rdy, 1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/safe_lock_ctrl.md
SAFE_LOCK_CTRL -- requirements
Module: safe_lock_ctrl

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, number of code bits per attempt (range 1..15).
REQ-002 SHALL have parameter MAX_FAIL, default 3, consecutive failures that trigger lockout (range 1..7).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 32, idle cycles allowed between bits of an attempt.
REQ-004 SHALL have parameter UNLOCK_CYC, default 16, cycles unlock stays asserted.
REQ-005 SHALL have parameter LOCKOUT_CYC, default 64, cycles locked_out stays asserted.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 key_val  in  1  keypad bit valid.
REQ-009 key_data  in  1  keypad bit value.
REQ-010 key_rdy  out  1  controller accepts key bits this cycle; a bit is accepted when key_val && key_rdy.
REQ-011 ser_val  out  1  bit valid to the code checker FSM.
REQ-012 ser_data  out  1  bit value to the code checker FSM.
REQ-013 chk_val  in  1  checker result valid (one-cycle pulse).
REQ-014 chk_ok  in  1  checker result: 1 = correct code, 0 = incorrect; sampled only with chk_val.
REQ-015 chk_rst  out  1  one-cycle synchronous clear pulse to the checker.
REQ-016 unlock  out  1  door release.
REQ-017 locked_out  out  1  lockout active.
REQ-018 fail_cnt  out  3  consecutive failure count.

Function
REQ-019 SHALL implement states IDLE, COLLECT, WAIT_RES, UNLOCK and LOCKOUT.
REQ-020 key_rdy SHALL be 1 only in IDLE and COLLECT.
REQ-021 Each accepted bit SHALL appear on ser_val=1/ser_data one cycle after acceptance; ser_val SHALL be 0 otherwise.
REQ-022 IDLE: an accepted bit SHALL set bit_cnt=1 and move to COLLECT.
REQ-023 COLLECT: each accepted bit SHALL increment bit_cnt; when bit_cnt reaches CODE_LEN, move to WAIT_RES.
REQ-024 The timeout counter SHALL clear on every accepted bit and on entering COLLECT, and count in COLLECT and WAIT_RES; reaching TIMEOUT_CYC SHALL be a failure and SHALL pulse chk_rst.
REQ-025 chk_val=1 with chk_ok=1 in COLLECT or WAIT_RES SHALL move to UNLOCK and clear fail_cnt.
REQ-026 chk_val=1 with chk_ok=0 in COLLECT or WAIT_RES SHALL be a failure (early reject allowed).
REQ-027 On a failure, fail_cnt SHALL increment; if the new value equals MAX_FAIL, move to LOCKOUT, else to IDLE.
REQ-028 UNLOCK: unlock=1 for exactly UNLOCK_CYC cycles, then IDLE.
REQ-029 LOCKOUT: locked_out=1 for exactly LOCKOUT_CYC cycles; key_val ignored; on exit, clear fail_cnt and go to IDLE.
REQ-030 chk_val outside COLLECT/WAIT_RES SHALL be ignored.
REQ-031 If chk_val and an accepted key coincide, the result SHALL win and the key bit SHALL be dropped (not forwarded).
REQ-032 If chk_val and timeout expiry coincide, the result SHALL win and chk_rst SHALL NOT pulse.
REQ-033 fail_cnt SHALL never exceed MAX_FAIL.

Reset
REQ-034 rst=1 SHALL force IDLE, with bit_cnt, timeout counter, fail_cnt and all cycle counters set to 0.
REQ-035 While rst=1, outputs SHALL be key_rdy=0, ser_val=0, ser_data=0, chk_rst=1, unlock=0, locked_out=0, fail_cnt=0 (alarm=0).
REQ-036 Reset mid-UNLOCK or mid-LOCKOUT SHALL deassert unlock/locked_out in the next cycle.

Configuration
REQ-037 Macro SAFE_LOCK_ALARM_EN defined: add output alarm (out, 1), asserted for the full LOCKOUT period and the first cycle of any chk_val in LOCKOUT/UNLOCK (tamper); undefined: no alarm port, behaviour otherwise identical.

Verification
REQ-038 Correct code 1,0,1,1 at 1 bit per 2 cycles, checker reports chk_ok=1 -> unlock=1 for 16 cycles, fail_cnt=0, then key_rdy=1.
REQ-039 Three wrong attempts (chk_ok=0) -> fail_cnt 1, 2, then locked_out=1 for 64 cycles, key_val ignored, then fail_cnt=0.
REQ-040 One bit then 32 idle cycles -> chk_rst pulse, fail_cnt=1, state IDLE.
REQ-041 chk_val=1 and key_val=1 in same COLLECT cycle -> result taken, ser_val stays 0 next cycle.
REQ-042 rst=1 during UNLOCK cycle 5 -> unlock=0 next cycle, fail_cnt=0, key_rdy=1 after release.
REQ-043 With SAFE_LOCK_ALARM_EN, third failure -> alarm=1 for 64 cycles coincident with locked_out.
